// File: rtl/exe_multicycle_ctrl_pkg.sv
// Shared encodings for the EX-stage multi-cycle sequencer: FSM states, op classes, unit op codes.
package exe_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OPC_SINGLE = 2'b00;
  localparam logic [1:0] OPC_MUL    = 2'b01;
  localparam logic [1:0] OPC_DIV    = 2'b10;

  typedef enum logic [0:0] {
    UOP_MUL = 1'b0,
    UOP_DIV = 1'b1
  } unit_op_e;

  // Class 11 is reserved and behaves like a single-cycle op.
  function automatic logic is_multicycle(input logic [1:0] opc);
    return (opc == OPC_MUL) || (opc == OPC_DIV);
  endfunction

endpackage

// File: rtl/exe_multicycle_ctrl_if.sv
// Pipeline <-> multi-cycle sequencer signal bundle; master is the pipeline, slave is the sequencer.
interface exe_multicycle_ctrl_if;
  logic        ex_valid;
  logic [1:0]  ex_op_class;
  logic        flush;
  logic        unit_start;
  logic        unit_op;
  logic        unit_abort;
  logic        stall;
  logic        ex_mem_bubble;
  logic        result_sel;
  logic        busy;
  logic [31:0] stall_cycles;

  modport master (
    output ex_valid, ex_op_class, flush,
    input  unit_start, unit_op, unit_abort, stall, ex_mem_bubble,
           result_sel, busy, stall_cycles
  );

  modport slave (
    input  ex_valid, ex_op_class, flush,
    output unit_start, unit_op, unit_abort, stall, ex_mem_bubble,
           result_sel, busy, stall_cycles
  );
endinterface

// File: rtl/exe_multicycle_ctrl_lat_down_counter.sv
// Loadable latency down-counter; holds at zero instead of wrapping.
module lat_down_counter #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != {CNT_W{1'b0}})) begin
      r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/exe_multicycle_ctrl.sv
// EX-stage MUL/DIV sequencer: launches the iterative unit, stalls the front end, aborts on flush.
// Optional stall performance counter enabled by defining EXE_PERF_CNT_EN.
module exe_multicycle_ctrl
  import exe_ctrl_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 16,
  parameter int CNT_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  exe_multicycle_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 2);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_op;
  logic             w_launch;
  logic             w_op;
  logic             w_zero;
  logic             w_dec;
  logic             w_stall;
  logic             w_abort;
  logic [CNT_W-1:0] w_load_val;

  assign w_launch   = (r_state == ST_IDLE) && bus.ex_valid &&
                      is_multicycle(bus.ex_op_class) && !bus.flush;
  assign w_op       = (bus.ex_op_class == OPC_DIV) ? UOP_DIV : UOP_MUL;
  assign w_load_val = (w_op == UOP_DIV) ? DIV_LOAD : MUL_LOAD;
  assign w_dec      = (r_state == ST_BUSY) && !bus.flush && !w_zero;
  assign w_abort    = (r_state == ST_BUSY) && bus.flush;
  assign w_stall    = w_launch || ((r_state == ST_BUSY) && !bus.flush);

  lat_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_launch),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Next-state decode; DONE never re-evaluates launch so the op is issued once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_launch) begin
          w_state_nxt = ST_BUSY;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (bus.flush) begin
          w_state_nxt = ST_IDLE;
        end else if (w_zero) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and latched op code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_launch) begin
        r_op <= w_op;
      end else begin
        r_op <= r_op;
      end
    end
  end

  // Launch and stall are combinational so the front end freezes in the entry cycle.
  assign bus.unit_start    = w_launch;
  assign bus.unit_op       = w_launch ? w_op : r_op;
  assign bus.unit_abort    = w_abort;
  assign bus.stall         = w_stall;
  assign bus.ex_mem_bubble = w_stall;
  assign bus.result_sel    = (r_state == ST_DONE);
  assign bus.busy          = w_launch || (r_state != ST_IDLE);

`ifdef EXE_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 32'h0000_0000;
    end else if (w_stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'h0000_0001;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
`else
  assign bus.stall_cycles = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_exe_multicycle_ctrl.sv
// Self-checking bench for exe_multicycle_ctrl against a timeline model of the launch/stall/done schedule.
module tb_exe_multicycle_ctrl;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 16;
  localparam int CNT_W   = 5;

  logic clk;
  logic rst_n;
  exe_multicycle_ctrl_if bus_if ();

  exe_multicycle_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: an op launched at cycle t0 with latency L stalls t0..t0+L-1 and shows its result at t0+L.
  int       cyc = 0;
  bit       m_active = 1'b0;
  int       m_t0 = 0;
  int       m_lat = 0;
  int       m_stalls = 0;
  logic [6:0]  exp_vec, got_vec;
  logic [31:0] e_perf;

  task automatic drive(input logic v, input logic [1:0] c, input logic f);
    logic e_start, e_op, e_abort, e_stall, e_rsel, e_busy;
    int k;
    @(negedge clk);
    bus_if.ex_valid    = v;
    bus_if.ex_op_class = c;
    bus_if.flush       = f;
    #1;
`ifdef EXE_PERF_CNT_EN
    e_perf = 32'(m_stalls);
`else
    e_perf = 32'd0;
`endif
    {e_start, e_op, e_abort, e_stall, e_rsel, e_busy} = 6'b000000;
    if (!m_active) begin
      if (v && (c == 2'b01 || c == 2'b10) && !f) begin
        e_start  = 1'b1;
        e_op     = (c == 2'b10);
        e_stall  = 1'b1;
        e_busy   = 1'b1;
        m_active = 1'b1;
        m_t0     = cyc;
        m_lat    = (c == 2'b10) ? DIV_LAT : MUL_LAT;
      end
    end else begin
      k = cyc - m_t0;
      e_busy = 1'b1;
      if (k >= m_lat) begin
        e_rsel   = 1'b1;
        m_active = 1'b0;
      end else if (f) begin
        e_abort  = 1'b1;
        m_active = 1'b0;
      end else begin
        e_stall = 1'b1;
      end
    end
    if (e_stall) m_stalls++;
    cyc++;
    exp_vec = {e_start, e_op, e_abort, e_stall, e_stall, e_rsel, e_busy};
    got_vec = {bus_if.unit_start, bus_if.unit_start & bus_if.unit_op, bus_if.unit_abort,
               bus_if.stall, bus_if.ex_mem_bubble, bus_if.result_sel, bus_if.busy};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.ex_valid = 1'b0; bus_if.ex_op_class = 2'b00; bus_if.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({got_vec, bus_if.unit_start, bus_if.unit_abort, bus_if.stall, bus_if.result_sel,
         bus_if.busy, bus_if.ex_mem_bubble, bus_if.unit_op} !== {got_vec, 7'b0000000}) begin
      n_err++;
      $display("FAIL reset_outputs got %b expected 0000000", {bus_if.unit_start, bus_if.unit_abort,
               bus_if.stall, bus_if.result_sel, bus_if.busy, bus_if.ex_mem_bubble, bus_if.unit_op});
    end
    n_vec++;
    if (bus_if.stall_cycles !== 32'd0) begin
      n_err++;
      $display("FAIL reset_perf got %0d expected 0", bus_if.stall_cycles);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    for (int i = 0; i < 7; i++) begin
      drive(i <= 4, 2'b01, 1'b0);
      n_vec++;
      if (got_vec !== exp_vec) begin
        n_err++;
        $display("FAIL mul cyc%0d got %b expected %b", i, got_vec, exp_vec);
      end
    end
  endtask

  task automatic test_div();
    int stalls = 0, busys = 0, rsels = 0;
    for (int i = 0; i < 19; i++) begin
      drive(i <= 16, 2'b10, 1'b0);
      stalls += bus_if.stall; busys += bus_if.busy; rsels += bus_if.result_sel;
      n_vec++;
      if (got_vec !== exp_vec) begin
        n_err++;
        $display("FAIL div cyc%0d got %b expected %b", i, got_vec, exp_vec);
      end
    end
    n_vec++;
    if (stalls !== DIV_LAT || busys !== DIV_LAT + 1 || rsels !== 1) begin
      n_err++;
      $display("FAIL div_counts got stall=%0d busy=%0d rsel=%0d expected %0d %0d 1",
               stalls, busys, rsels, DIV_LAT, DIV_LAT + 1);
    end
  endtask

  task automatic test_flush_div();
    int rsels = 0, aborts = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i <= 5, 2'b10, i == 5);
      rsels += bus_if.result_sel; aborts += bus_if.unit_abort;
      n_vec++;
      if (got_vec !== exp_vec) begin
        n_err++;
        $display("FAIL flush_div cyc%0d got %b expected %b", i, got_vec, exp_vec);
      end
    end
    n_vec++;
    if (rsels !== 0 || aborts !== 1) begin
      n_err++;
      $display("FAIL flush_div_counts got rsel=%0d abort=%0d expected 0 1", rsels, aborts);
    end
  endtask

  task automatic test_back_to_back();
    int starts = 0;
    logic [9:0] stall_pat;
    for (int i = 0; i < 12; i++) begin
      drive(i <= 9, 2'b01, 1'b0);
      starts += bus_if.unit_start;
      if (i < 10) stall_pat[9-i] = bus_if.stall;
      n_vec++;
      if (got_vec !== exp_vec) begin
        n_err++;
        $display("FAIL b2b cyc%0d got %b expected %b", i, got_vec, exp_vec);
      end
    end
    n_vec++;
    if (starts !== 2 || stall_pat !== 10'b1111011110) begin
      n_err++;
      $display("FAIL b2b_pattern got starts=%0d stalls=%b expected 2 1111011110", starts, stall_pat);
    end
  endtask

  task automatic test_single();
    int act = 0;
    for (int i = 0; i < 24; i++) begin
      if (i < 20) drive(1'b1, (i % 2 == 0) ? 2'b00 : 2'b11, 1'b0);
      else        drive(1'b0, 2'b01, 1'b0);
      act += bus_if.stall + bus_if.unit_start + bus_if.busy;
      n_vec++;
      if (got_vec !== exp_vec) begin
        n_err++;
        $display("FAIL single cyc%0d got %b expected %b", i, got_vec, exp_vec);
      end
    end
    n_vec++;
    if (act !== 0) begin
      n_err++;
      $display("FAIL single_activity got %0d expected 0", act);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] perf_exp;
    drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b01, 1'b0);
    @(negedge clk);
    bus_if.ex_valid = 1'b0; bus_if.ex_op_class = 2'b00; bus_if.flush = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus_if.unit_start, bus_if.unit_abort, bus_if.stall, bus_if.result_sel, bus_if.busy,
         bus_if.ex_mem_bubble, bus_if.unit_op, bus_if.stall_cycles} !== 39'd0) begin
      n_err++;
      $display("FAIL reset_mid_op got %b perf=%0d expected all 0", {bus_if.unit_start,
               bus_if.unit_abort, bus_if.stall, bus_if.result_sel, bus_if.busy,
               bus_if.ex_mem_bubble, bus_if.unit_op}, bus_if.stall_cycles);
    end
    m_active = 1'b0;
    m_stalls = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(i <= 4, 2'b01, 1'b0);
      n_vec++;
      if (got_vec !== exp_vec) begin
        n_err++;
        $display("FAIL post_reset_mul cyc%0d got %b expected %b", i, got_vec, exp_vec);
      end
    end
`ifdef EXE_PERF_CNT_EN
    perf_exp = 32'd4;
`else
    perf_exp = 32'd0;
`endif
    n_vec++;
    if (bus_if.stall_cycles !== perf_exp) begin
      n_err++;
      $display("FAIL perf_one_mul got %0d expected %0d", bus_if.stall_cycles, perf_exp);
    end
  endtask

  task automatic test_random();
    logic v, f;
    logic [1:0] c;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(3, 0) != 0);
      c = 2'($urandom_range(3, 0));
      f = ($urandom_range(15, 0) == 0);
      drive(v, c, f);
      n_vec++;
      if (got_vec !== exp_vec) begin
        n_err++;
        $display("FAIL random cyc%0d in=%b%b%b got %b expected %b", i, v, c, f, got_vec, exp_vec);
      end
      n_vec++;
      if (bus_if.stall_cycles !== e_perf) begin
        n_err++;
        $display("FAIL random_perf cyc%0d got %0d expected %0d", i, bus_if.stall_cycles, e_perf);
      end
    end
  endtask

  initial begin
    got_vec = 7'd0;
    exp_vec = 7'd0;
    e_perf  = 32'd0;
    test_reset();
    test_mul();
    test_div();
    test_flush_div();
    test_back_to_back();
    test_single();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
